// File: rtl/i2c_cfg_seq.sv
// Register-initialisation sequencer: walks a {reg, data} table and issues I2C write
// transactions (with optional read-back compare) to the byte driver, retrying on failure.
module i2c_cfg_seq #(
    parameter int          CFG_NUM   = 64,
    parameter logic [7:0]  DEV_ADDR  = 8'h78,
    parameter int          MAX_RETRY = 3,
    parameter int          GAP_CYC   = 16,
    parameter int          DLY_UNIT  = 1024,
    parameter int          BUSY_TMO  = 4096,
    parameter bit          VERIFY    = 1'b0,
    localparam int         AW        = $clog2(CFG_NUM)
) (
    input  logic          clk_i,
    input  logic          rst,
    input  logic          cfg_start,
    output logic [AW-1:0] tbl_addr,
    input  logic [23:0]   tbl_data,
    output logic          drv_start_en,
    output logic          drv_wr_rd_flag,
    output logic [7:0]    drv_dev_addr,
    output logic [15:0]   drv_register,
    output logic [7:0]    drv_data_byte,
    input  logic          drv_busy,
    input  logic          drv_err,
    input  logic [7:0]    drv_rd_data,
    output logic          cfg_busy,
    output logic          cfg_done,
    output logic          cfg_fail,
    output logic [AW-1:0] fail_idx,
    output logic [15:0]   wr_count
);

    localparam int CW       = $clog2(BUSY_TMO + GAP_CYC + 9);
    localparam int DW       = $clog2(255 * DLY_UNIT + 1);
    localparam int RW       = $clog2(MAX_RETRY + 2);
    localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
    localparam logic [AW-1:0] LAST_IDX = AW'(CFG_NUM - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_FETCH_W, S_DECODE, S_ISSUE, S_WAIT_H,
        S_WAIT_L, S_CHECK, S_GAP, S_DELAY, S_DONE, S_FAIL
    } state_t;

    state_t          state;
    state_t          gap_ret;
    logic [AW-1:0]   idx;
    logic [15:0]     ent_reg;
    logic [7:0]      ent_data;
    logic            rd_phase;
    logic            err_l;
    logic [RW-1:0]   attempts;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   dly_cnt;

    assign tbl_addr     = idx;
    assign drv_dev_addr = DEV_ADDR;
    assign cfg_busy     = (state != S_IDLE) && (state != S_DONE) && (state != S_FAIL);

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            gap_ret        <= S_FETCH;
            idx            <= '0;
            ent_reg        <= '0;
            ent_data       <= '0;
            rd_phase       <= 1'b0;
            err_l          <= 1'b0;
            attempts       <= '0;
            cnt            <= '0;
            dly_cnt        <= '0;
            drv_start_en   <= 1'b0;
            drv_wr_rd_flag <= 1'b0;
            drv_register   <= '0;
            drv_data_byte  <= '0;
            cfg_done       <= 1'b0;
            cfg_fail       <= 1'b0;
            fail_idx       <= '0;
            wr_count       <= '0;
        end else begin
            drv_start_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (cfg_start) begin
                        idx      <= '0;
                        wr_count <= '0;
                        cfg_done <= 1'b0;
                        cfg_fail <= 1'b0;
                        fail_idx <= '0;
                        state    <= S_FETCH;
                    end
                end
                // The ROM registers tbl_addr this cycle; its data is usable in S_FETCH_W.
                S_FETCH: state <= S_FETCH_W;
                S_FETCH_W: begin
                    ent_reg  <= tbl_data[23:8];
                    ent_data <= tbl_data[7:0];
                    state    <= S_DECODE;
                end
                S_DECODE: begin
                    if (ent_reg == 16'hFFFF) begin
                        cfg_done <= 1'b1;
                        state    <= S_DONE;
                    end else if (ent_reg == 16'hFFFE) begin
                        dly_cnt <= DW'(ent_data) * DW'(DLY_UNIT);
                        state   <= S_DELAY;
                    end else begin
                        rd_phase       <= 1'b0;
                        attempts       <= '0;
                        err_l          <= 1'b0;
                        drv_start_en   <= 1'b1;
                        drv_wr_rd_flag <= 1'b0;
                        drv_register   <= ent_reg;
                        drv_data_byte  <= ent_data;
                        state          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT_H;
                end
                // A missing busy response or a stuck busy is folded into err_l so CHECK decides.
                S_WAIT_H: begin
                    if (drv_busy) begin
                        err_l <= err_l | drv_err;
                        cnt   <= '0;
                        state <= S_WAIT_L;
                    end else if (cnt == CW'(7)) begin
                        err_l <= 1'b1;
                        state <= S_CHECK;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WAIT_L: begin
                    if (!drv_busy) begin
                        state <= S_CHECK;
                    end else begin
                        err_l <= err_l | drv_err | (cnt == CW'(BUSY_TMO - 1));
                        if (cnt == CW'(BUSY_TMO - 1))
                            state <= S_CHECK;
                        else
                            cnt <= cnt + CW'(1);
                    end
                end
                S_CHECK: begin
                    cnt   <= '0;
                    err_l <= 1'b0;
                    state <= S_GAP;
                    if (err_l || (rd_phase && (drv_rd_data != ent_data))) begin
                        if (attempts < RW'(MAX_RETRY)) begin
                            attempts <= attempts + RW'(1);
                            rd_phase <= 1'b0;
                            gap_ret  <= S_ISSUE;
                        end else begin
                            fail_idx <= idx;
                            cfg_fail <= 1'b1;
                            state    <= S_FAIL;
                        end
                    end else if (!rd_phase && VERIFY) begin
                        rd_phase <= 1'b1;
                        gap_ret  <= S_ISSUE;
                    end else begin
                        if (wr_count != 16'hFFFF)
                            wr_count <= wr_count + 16'd1;
                        if (idx == LAST_IDX) begin
                            cfg_done <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            idx     <= idx + AW'(1);
                            gap_ret <= S_FETCH;
                        end
                    end
                end
                S_GAP: begin
                    if (cnt >= CW'(GAP_LAST)) begin
                        state <= gap_ret;
                        if (gap_ret == S_ISSUE) begin
                            drv_start_en   <= 1'b1;
                            drv_wr_rd_flag <= rd_phase;
                            drv_register   <= ent_reg;
                            drv_data_byte  <= ent_data;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DELAY: begin
                    if (dly_cnt == '0) begin
                        if (idx == LAST_IDX) begin
                            cfg_done <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            idx   <= idx + AW'(1);
                            state <= S_FETCH;
                        end
                    end else begin
                        dly_cnt <= dly_cnt - DW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/i2c_cfg_seq.md
# i2c_cfg_seq

Register-initialisation sequencer that sits in front of the I2C byte driver. It walks a configuration table, with one entry per 16-bit register address plus 8-bit data. For each entry it issues a write transaction to the driver. It can optionally read the register back and compare the result. Failed transfers are retried, and the sequencer reports done or fail to the camera bring-up logic.

## Interface
Parameters:
- CFG_NUM, 64: number of table entries; table address width is clog2(CFG_NUM).
- DEV_ADDR, 8'h78: device address byte driven to the driver.
- MAX_RETRY, 3: retries per entry after the first attempt.
- GAP_CYC, 16: idle cycles between driver transactions.
- DLY_UNIT, 1024: cycles per unit of a delay entry.
- BUSY_TMO, 4096: maximum cycles busy may stay high.
- VERIFY, 0: 1 enables read-back compare after each write.

Ports:
- clk_i, in, 1: driver clock (same clock as the I2C driver).
- rst, in, 1: asynchronous active-high reset.
- cfg_start, in, 1: one-cycle start pulse; ignored unless in IDLE, DONE or FAIL.
- tbl_addr, out, clog2(CFG_NUM): table read address.
- tbl_data, in, 24: {reg[15:0], data[7:0]}; valid 1 cycle after tbl_addr (registered ROM).
- drv_start_en, out, 1: one-cycle start pulse to the driver.
- drv_wr_rd_flag, out, 1: 0 = write, 1 = read.
- drv_dev_addr, out, 8: driver device address byte.
- drv_register, out, 16: driver register address.
- drv_data_byte, out, 8: driver write data.
- drv_busy, in, 1: driver busy.
- drv_err, in, 1: driver ACK error (transient).
- drv_rd_data, in, 8: driver read data.
- cfg_busy, out, 1: sequence in progress.
- cfg_done, out, 1: table completed.
- cfg_fail, out, 1: sequence aborted.
- fail_idx, out, clog2(CFG_NUM): entry index that failed.
- wr_count, out, 16: entries written successfully.

## Operation
Entry decode:
- reg == 16'hFFFF: end of table; go to DONE.
- reg == 16'hFFFE: delay entry; wait data×DLY_UNIT cycles (data = 0 means no wait), no bus access.
- Any other value: register write.
- Reaching index CFG_NUM-1 without an end marker: DONE after that entry completes.

States:
- IDLE: on cfg_start, clear idx, wr_count, cfg_done, cfg_fail and fail_idx; go to FETCH.
- FETCH: drive tbl_addr = idx; wait one cycle; latch tbl_data; go to DECODE.
- DECODE: end marker → DONE; delay entry → DELAY; otherwise set phase = WR, attempts = 0, go to ISSUE.
- ISSUE: pulse drv_start_en for one cycle with driver fields stable. In the WR phase drive flag = 0 and data = entry data. In the RD phase drive flag = 1. Drive drv_register = entry reg. Go to WAIT_H.
- WAIT_H: wait for drv_busy = 1. If it is not seen within 8 cycles, the attempt fails.
- WAIT_L: OR drv_err into a sticky err_l each cycle while busy is high. Busy low → CHECK. Busy high for BUSY_TMO cycles → attempt fails.
- CHECK:
  - err_l = 1 → attempt fails.
  - WR phase succeeded and VERIFY = 1: phase = RD, go to GAP, then ISSUE.
  - RD phase: drv_rd_data ≠ entry data → attempt fails.
  - Success otherwise: wr_count +1 (saturating), idx +1, go to GAP then FETCH.
- Attempt fail: if attempts < MAX_RETRY, increment attempts, set phase = WR, go to GAP then ISSUE. Otherwise fail_idx = idx, go to FAIL.
- DELAY: count the delay down, then idx +1, go to FETCH.
- GAP: count GAP_CYC cycles; err_l cleared on entry.
- DONE / FAIL: hold status flags; cfg_start restarts the sequence from IDLE behaviour.

Outputs:
- drv_dev_addr = DEV_ADDR constant. The driver appends the R/W bit itself.
- cfg_busy = 1 in every state except IDLE, DONE and FAIL.

## Timing
- Reset: state IDLE; every output is 0 except drv_dev_addr = DEV_ADDR; counters and err_l are cleared.
- drv_start_en is high for exactly 1 cycle per transaction. drv_register, drv_data_byte and drv_wr_rd_flag are registered, set no later than the pulse cycle, and held until the next ISSUE.
- Latency from cfg_start to the first drv_start_en: 4 cycles (IDLE→FETCH, ROM latency, DECODE, ISSUE).
- The GAP of GAP_CYC cycles is inserted between a busy falling edge and the next drv_start_en.
- cfg_start arriving while cfg_busy = 1 is ignored.
- Reset mid-transaction: the sequencer returns to IDLE immediately. drv_start_en drops, and the driver's own reset is the system's responsibility.
- drv_err toggling while busy = 0 is ignored.

## Test plan
- **4-entry table ending in FFFF, VERIFY = 0, ACKing slave model:** 3 write transactions with correct reg and data, GAP_CYC idle cycles between them; cfg_done = 1, wr_count = 3, cfg_fail = 0.
- **Slave NACKs entry 1 twice, then ACKs, MAX_RETRY = 3:** entry 1 issued 3 times; sequence completes with cfg_done = 1.
- **Slave always NACKs entry 2:** 4 attempts on entry 2; cfg_fail = 1, fail_idx = 2, wr_count = 2, no further drv_start_en.
- **VERIFY = 1, slave returns 8'h5A for write data 8'hA5:** each attempt issues a write then a read; after 4 attempts cfg_fail = 1.
- **Delay entry FFFE/03 with DLY_UNIT = 4:** 12 cycles with no bus activity between the surrounding writes.
- **drv_busy stuck at 0, plus assert rst during WAIT_L:** the stuck-busy case exhausts retries and sets cfg_fail. The reset case immediately gives cfg_busy = 0 and all outputs at their reset values.
